// File: rtl/seq_checker.sv
// seq_checker: watches the 4-bit code stream of an upstream 8-state counter,
// acquires lock after LOCK_N consecutive correct transitions, and then flags
// sequence faults and counts completed laps. Every output is registered.
module seq_checker #(
  parameter int unsigned LOCK_N = 3
) (
  input  logic       C,
  input  logic       nR,
  input  logic [3:0] Q,
  input  logic       clr,
  output logic       lock,
  output logic       err,
  output logic [3:0] err_cnt,
  output logic [2:0] idx,
  output logic       idx_v,
  output logic       wrap,
  output logic [7:0] lap_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  // Run target widened to the run-increment width; LOCK_N is limited to 1..7.
  localparam logic [3:0] LP_LOCK_N    = 4'(LOCK_N);
  localparam logic [3:0] LP_LAP_FROM  = 4'd6;
  localparam logic [3:0] LP_LAP_TO    = 4'd10;
  localparam logic [3:0] LP_ERR_MAX   = 4'd15;

  // Membership in the legal code set 10,4,12,9,2,1,3,6.
  function automatic logic code_legal(input logic [3:0] code);
    case (code)
      4'd10, 4'd4, 4'd12, 4'd9,
      4'd2,  4'd1, 4'd3,  4'd6: code_legal = 1'b1;
      default:                  code_legal = 1'b0;
    endcase
  endfunction

  // Position of a code within the lap; illegal codes report position 0.
  function automatic logic [2:0] code_idx(input logic [3:0] code);
    case (code)
      4'd10:   code_idx = 3'd0;
      4'd4:    code_idx = 3'd1;
      4'd12:   code_idx = 3'd2;
      4'd9:    code_idx = 3'd3;
      4'd2:    code_idx = 3'd4;
      4'd1:    code_idx = 3'd5;
      4'd3:    code_idx = 3'd6;
      4'd6:    code_idx = 3'd7;
      default: code_idx = 3'd0;
    endcase
  endfunction

  // Expected next code; illegal codes have no successor and return 0, which
  // is itself illegal, and callers also qualify with code_legal().
  function automatic logic [3:0] code_succ(input logic [3:0] code);
    case (code)
      4'd10:   code_succ = 4'd4;
      4'd4:    code_succ = 4'd12;
      4'd12:   code_succ = 4'd9;
      4'd9:    code_succ = 4'd2;
      4'd2:    code_succ = 4'd1;
      4'd1:    code_succ = 4'd3;
      4'd3:    code_succ = 4'd6;
      4'd6:    code_succ = 4'd10;
      default: code_succ = 4'd0;
    endcase
  endfunction

  // Saturating increment for the fault counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    if (val == LP_ERR_MAX) sat_inc4 = LP_ERR_MAX;
    else                   sat_inc4 = val + 4'd1;
  endfunction

  state_t     r_state;
  logic [2:0] r_run;
  logic [3:0] r_prev;
  logic       r_prev_v;

  logic       w_q_legal;
  logic       w_correct;
  logic [3:0] w_run_inc;
  logic       w_fault_ev;
  logic       w_lap_ev;

  // The stored previous sample only counts once a sample exists since reset,
  // so the first sample after reset can never form a transition.
  assign w_q_legal  = code_legal(Q);
  assign w_correct  = r_prev_v & code_legal(r_prev) & (Q == code_succ(r_prev));
  assign w_run_inc  = {1'b0, r_run} + 4'd1;
  assign w_fault_ev = (r_state == LOCK) & ~w_correct;
  assign w_lap_ev   = (r_state == LOCK) & w_correct &
                      (r_prev == LP_LAP_FROM) & (Q == LP_LAP_TO);

  // Acquisition FSM with registered lock/err/wrap outputs.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      r_state <= SEARCH;
      r_run   <= 3'd0;
      lock    <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      lock <= 1'b0;
      err  <= 1'b0;
      wrap <= 1'b0;
      case (r_state)
        ACQ: begin
          if (w_correct) begin
            r_run <= w_run_inc[2:0];
            if (w_run_inc == LP_LOCK_N) begin
              // The completing transition never produces wrap, even if 6->10.
              r_state <= LOCK;
              lock    <= 1'b1;
            end
          end else if (w_q_legal) begin
            r_run <= 3'd0;
          end else begin
            r_state <= SEARCH;
            r_run   <= 3'd0;
          end
        end
        LOCK: begin
          if (w_correct) begin
            lock <= 1'b1;
            wrap <= w_lap_ev;
          end else begin
            r_state <= FAULT;
            r_run   <= 3'd0;
            err     <= 1'b1;
          end
        end
        default: begin
          // SEARCH and the single FAULT cycle share the same entry rule.
          r_run   <= 3'd0;
          r_state <= w_q_legal ? ACQ : SEARCH;
        end
      endcase
    end
  end

  // Fault and lap counters; clr wins over a simultaneous increment.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      err_cnt <= 4'd0;
      lap_cnt <= 8'd0;
    end else if (clr) begin
      err_cnt <= 4'd0;
      lap_cnt <= 8'd0;
    end else begin
      if (w_fault_ev) err_cnt <= sat_inc4(err_cnt);
      if (w_lap_ev)   lap_cnt <= lap_cnt + 8'd1;
    end
  end

  // Per-sample position decode and previous-sample store.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      idx      <= 3'd0;
      idx_v    <= 1'b0;
      r_prev   <= 4'd0;
      r_prev_v <= 1'b0;
    end else begin
      idx      <= code_idx(Q);
      idx_v    <= w_q_legal;
      r_prev   <= Q;
      r_prev_v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: scoreboard bench for seq_checker with LOCK_N=3. A behavioural
// model predicts the outputs of every posedge; predictions are queued when Q is
// driven and popped when the DUT outputs settle after the edge.
module tb_seq_checker;

  localparam int LOCK_N = 3;
  localparam logic [3:0] SEQ [8] = '{4'd10, 4'd4, 4'd12, 4'd9, 4'd2, 4'd1, 4'd3, 4'd6};
  localparam int ST_SEARCH = 0;
  localparam int ST_ACQ    = 1;
  localparam int ST_LOCK   = 2;
  localparam int ST_FAULT  = 3;

  logic       C = 1'b0;
  logic       nR;
  logic [3:0] Q;
  logic       clr;
  logic       lock;
  logic       err;
  logic [3:0] err_cnt;
  logic [2:0] idx;
  logic       idx_v;
  logic       wrap;
  logic [7:0] lap_cnt;

  seq_checker #(.LOCK_N(LOCK_N)) dut (
    .C       (C),
    .nR      (nR),
    .Q       (Q),
    .clr     (clr),
    .lock    (lock),
    .err     (err),
    .err_cnt (err_cnt),
    .idx     (idx),
    .idx_v   (idx_v),
    .wrap    (wrap),
    .lap_cnt (lap_cnt)
  );

  always #5 C = ~C;

  typedef struct {
    logic       lock;
    logic       err;
    logic [3:0] ec;
    logic [2:0] idx;
    logic       iv;
    logic       wrap;
    logic [7:0] lap;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model state
  int         m_st;
  int         m_run;
  logic [3:0] m_prev;
  bit         m_prev_v;
  int         m_ec;
  int         m_lap;
  logic [3:0] last_q;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int find(input logic [3:0] v);
    for (int i = 0; i < 8; i++) if (SEQ[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_st     = ST_SEARCH;
    m_run    = 0;
    m_prev   = 4'd0;
    m_prev_v = 1'b0;
    m_ec     = 0;
    m_lap    = 0;
  endtask

  task automatic model_step(input logic [3:0] q, input logic c, output exp_t e);
    int qi;
    int pi;
    bit corr;
    bit inc_err;
    bit inc_lap;
    qi = find(q);
    pi = m_prev_v ? find(m_prev) : -1;
    corr = (pi >= 0) && (qi >= 0) && (qi == (pi + 1) % 8);
    e.err = 1'b0;
    e.wrap = 1'b0;
    inc_err = 1'b0;
    inc_lap = 1'b0;
    case (m_st)
      ST_ACQ: begin
        if (corr) begin
          m_run++;
          if (m_run == LOCK_N) m_st = ST_LOCK;
        end else if (qi >= 0) m_run = 0;
        else m_st = ST_SEARCH;
      end
      ST_LOCK: begin
        if (corr) begin
          if (qi == 0) begin
            e.wrap = 1'b1;
            inc_lap = 1'b1;
          end
        end else begin
          m_st = ST_FAULT;
          e.err = 1'b1;
          inc_err = 1'b1;
        end
      end
      default: begin
        m_run = 0;
        m_st = (qi >= 0) ? ST_ACQ : ST_SEARCH;
      end
    endcase
    if (c) begin
      m_ec = 0;
      m_lap = 0;
    end else begin
      if (inc_err && m_ec < 15) m_ec++;
      if (inc_lap) m_lap = (m_lap + 1) % 256;
    end
    e.lock = (m_st == ST_LOCK);
    e.ec   = 4'(m_ec);
    e.lap  = 8'(m_lap);
    e.idx  = (qi >= 0) ? 3'(qi) : 3'd0;
    e.iv   = (qi >= 0);
    m_prev = q;
    m_prev_v = 1'b1;
  endtask

  // Drive one sample at the negedge, predict, then compare after the posedge.
  task automatic drive(input logic [3:0] q, input logic c);
    exp_t e;
    exp_t g;
    @(negedge C);
    Q = q;
    clr = c;
    model_step(q, c, e);
    sb.push_back(e);
    @(posedge C);
    #1;
    g = sb.pop_front();
    chk_val("lock",    32'(lock),    32'(g.lock));
    chk_val("err",     32'(err),     32'(g.err));
    chk_val("err_cnt", 32'(err_cnt), 32'(g.ec));
    chk_val("idx",     32'(idx),     32'(g.idx));
    chk_val("idx_v",   32'(idx_v),   32'(g.iv));
    chk_val("wrap",    32'(wrap),    32'(g.wrap));
    chk_val("lap_cnt", 32'(lap_cnt), 32'(g.lap));
    clr = 1'b0;
    last_q = q;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_val({pfx, "_lock"},    32'(lock),    32'd0);
    chk_val({pfx, "_err"},     32'(err),     32'd0);
    chk_val({pfx, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk_val({pfx, "_idx"},     32'(idx),     32'd0);
    chk_val({pfx, "_idx_v"},   32'(idx_v),   32'd0);
    chk_val({pfx, "_wrap"},    32'(wrap),    32'd0);
    chk_val({pfx, "_lap_cnt"}, 32'(lap_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int         p;
    logic [3:0] nq;
    logic       nc;
    nR = 1'b0;
    Q = 4'd0;
    clr = 1'b0;
    last_q = 4'd0;
    model_reset();
    repeat (2) @(posedge C);
    #1;
    chk_all_zero("rst");
    nR = 1'b1;

    // Acquisition from reset
    drive(4'd10, 1'b0);
    drive(4'd4, 1'b0);
    drive(4'd12, 1'b0);
    chk_val("acq_not_yet", 32'(lock), 32'd0);
    drive(4'd9, 1'b0);
    chk_val("acq_lock", 32'(lock), 32'd1);
    chk_val("acq_idx", 32'(idx), 32'd3);
    chk_val("acq_idx_v", 32'(idx_v), 32'd1);

    // One lap through 6->10
    drive(4'd2, 1'b0);
    drive(4'd1, 1'b0);
    drive(4'd3, 1'b0);
    drive(4'd6, 1'b0);
    chk_val("wrap_early", 32'(wrap), 32'd0);
    drive(4'd10, 1'b0);
    chk_val("wrap_pulse", 32'(wrap), 32'd1);
    chk_val("lap_one", 32'(lap_cnt), 32'd1);
    drive(4'd4, 1'b0);
    chk_val("wrap_drop", 32'(wrap), 32'd0);
    drive(4'd12, 1'b0);

    // Fault while locked at 12
    drive(4'd2, 1'b0);
    chk_val("fault_err", 32'(err), 32'd1);
    chk_val("fault_cnt", 32'(err_cnt), 32'd1);
    chk_val("fault_lock", 32'(lock), 32'd0);
    drive(4'd1, 1'b0);
    chk_val("fault_err_once", 32'(err), 32'd0);
    chk_val("fault_acq_lock", 32'(lock), 32'd0);

    // Acquisition completing on 6->10 must not wrap
    drive(4'd3, 1'b0);
    drive(4'd6, 1'b0);
    drive(4'd10, 1'b0);
    chk_val("acq_lock2", 32'(lock), 32'd1);
    chk_val("acq_no_wrap", 32'(wrap), 32'd0);
    chk_val("acq_no_lap", 32'(lap_cnt), 32'd1);

    // 256 laps return lap_cnt to its starting value
    for (int l = 0; l < 256; l++)
      for (int i = 1; i <= 8; i++) drive(SEQ[i % 8], 1'b0);
    chk_val("lap_mod256", 32'(lap_cnt), 32'd1);

    // Illegal code in ACQ returns to SEARCH
    drive(4'd0, 1'b0);
    drive(4'd10, 1'b0);
    drive(4'd7, 1'b0);
    chk_val("illegal_idx_v", 32'(idx_v), 32'd0);
    chk_val("illegal_idx", 32'(idx), 32'd0);
    drive(4'd4, 1'b0);
    drive(4'd12, 1'b0);
    drive(4'd9, 1'b0);
    chk_val("reacq_not_yet", 32'(lock), 32'd0);
    drive(4'd2, 1'b0);
    chk_val("reacq_lock", 32'(lock), 32'd1);

    // Fault counter saturation, then clr on a fault edge
    for (int k = 0; k < 17; k++) begin
      drive(4'd0, 1'b0);
      drive(4'd10, 1'b0);
      drive(4'd4, 1'b0);
      drive(4'd12, 1'b0);
      drive(4'd9, 1'b0);
    end
    chk_val("err_sat", 32'(err_cnt), 32'd15);
    drive(4'd0, 1'b1);
    chk_val("clr_err_pulse", 32'(err), 32'd1);
    chk_val("clr_err_cnt", 32'(err_cnt), 32'd0);

    // clr against a simultaneous lap increment
    drive(4'd10, 1'b0);
    drive(4'd4, 1'b0);
    drive(4'd12, 1'b0);
    drive(4'd9, 1'b0);
    drive(4'd2, 1'b0);
    drive(4'd1, 1'b0);
    drive(4'd3, 1'b0);
    drive(4'd6, 1'b0);
    drive(4'd10, 1'b1);
    chk_val("clr_wrap_kept", 32'(wrap), 32'd1);
    chk_val("clr_lap_prio", 32'(lap_cnt), 32'd0);
    chk_val("clr_lock_kept", 32'(lock), 32'd1);

    // Mostly-sequential random traffic with occasional faults and clears
    for (int k = 0; k < 400; k++) begin
      p = find(last_q);
      if (p >= 0 && $urandom_range(99, 0) < 85) nq = SEQ[(p + 1) % 8];
      else nq = 4'($urandom_range(15, 0));
      nc = ($urandom_range(99, 0) < 3);
      drive(nq, nc);
    end

    // Lock again, then reset between clock edges
    drive(4'd10, 1'b0);
    drive(4'd4, 1'b0);
    drive(4'd12, 1'b0);
    drive(4'd9, 1'b0);
    drive(4'd2, 1'b0);
    drive(4'd1, 1'b0);
    chk_val("pre_arst_lock", 32'(lock), 32'd1);
    #2;
    nR = 1'b0;
    model_reset();
    #1;
    chk_all_zero("arst");
    nR = 1'b1;
    drive(4'd4, 1'b0);
    chk_val("post_rst_first", 32'(lock), 32'd0);
    drive(4'd12, 1'b0);
    drive(4'd9, 1'b0);
    drive(4'd2, 1'b0);
    chk_val("post_rst_lock", 32'(lock), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter: LOCK_N, 3, number of consecutive correct transitions required to declare lock; legal range 1..7.
REQ-002 Port: C  input  1  clock; all state updates on posedge C, so the upstream counter's negedge-updated code is mid-cycle stable.
REQ-003 Port: nR  input  1  reset, asynchronous, active-low.
REQ-004 Port: Q  input  4  code from the upstream 8-state counter.
REQ-005 Port: clr  input  1  synchronous clear of err_cnt and lap_cnt.
REQ-006 Port: lock  output  1  high while the checker is in state LOCK.
REQ-007 Port: err  output  1  one-cycle pulse on a sequence fault while locked.
REQ-008 Port: err_cnt  output  4  fault count, saturating.
REQ-009 Port: idx  output  3  position of the last sample in the sequence.
REQ-010 Port: idx_v  output  1  last sample was a legal code.
REQ-011 Port: wrap  output  1  one-cycle pulse on a locked 6->10 transition.
REQ-012 Port: lap_cnt  output  8  completed-lap count, modulo 256.

Function
REQ-013 Legal sequence SHALL be 10,4,12,9,2,1,3,6, then back to 10, with idx 0..7 in that order.
REQ-014 Codes 0,5,7,8,11,13,14,15 SHALL be illegal, have no successor, and produce idx_v=0 and idx=0.
REQ-015 Each posedge C SHALL sample Q, register idx/idx_v for it, and store it as prev for the next comparison.
REQ-016 A transition SHALL be "correct" when prev is legal and Q equals succ(prev).
REQ-017 FSM states SHALL be SEARCH, ACQ, LOCK and FAULT, with a run counter 0..LOCK_N.
REQ-018 SEARCH: a legal Q SHALL move to ACQ with run=0; an illegal Q SHALL stay in SEARCH.
REQ-019 ACQ on a correct transition SHALL increment run, and SHALL move to LOCK when run reaches LOCK_N.
REQ-020 ACQ on an incorrect transition SHALL stay in ACQ with run=0 if Q is legal, else return to SEARCH.
REQ-021 LOCK on a correct transition SHALL stay in LOCK; any incorrect transition, including an illegal Q, SHALL move to FAULT.
REQ-022 FAULT SHALL last exactly one cycle, then evaluate Q as SEARCH does.
REQ-023 lock SHALL be a registered decode of state==LOCK, rising at the posedge that samples the LOCK_N-th correct transition.
REQ-024 On the LOCK->FAULT edge, err SHALL assert for that cycle only and err_cnt SHALL increment, saturating at 15.
REQ-025 wrap SHALL pulse for one cycle when, in LOCK, a correct 6->10 transition is sampled; lap_cnt SHALL then increment, 255 wrapping to 0.
REQ-026 The transition that completes acquisition SHALL NOT produce wrap, even when it is 6->10.
REQ-027 clr SHALL zero err_cnt and lap_cnt at the next posedge and SHALL take priority over a simultaneous increment.
REQ-028 clr SHALL NOT affect state, run, lock, err or wrap.
REQ-029 All outputs SHALL be registered; no output may combinationally depend on Q.

Reset
REQ-030 nR low SHALL immediately force state=SEARCH, run=0, prev invalid, and all outputs to 0, independent of C.
REQ-031 Reset assertion mid-LOCK SHALL drop lock without a clock edge; release SHALL resume sampling at the next posedge.
REQ-032 The first sample after reset SHALL never count as a transition.

Verification (LOCK_N=3)
REQ-033 Reset, then Q=10,4,12,9 on successive posedges -> lock=1 after the 4th edge; idx=3, idx_v=1.
REQ-034 Locked at Q=12, then drive Q=2 -> err=1 for one cycle, err_cnt=1, lock=0 for one cycle (FAULT), then ACQ.
REQ-035 Locked, run through 3,6,10 -> wrap pulses on the 10 sample only, lap_cnt 0->1; 256 laps -> lap_cnt=0.
REQ-036 In ACQ, drive Q=7 -> idx_v=0 and state SEARCH; then 4,12,9,2 -> lock=1 on the 2 sample.
REQ-037 Force 16 faults -> err_cnt holds 15; assert clr on a fault edge -> err_cnt=0 and err=1 in the same cycle.
REQ-038 Pull nR low between clock edges while locked -> lock, err_cnt, lap_cnt, idx, idx_v all 0 before the next edge.
